// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent toggle flip-flops with a common clock enable.
// Optional complement output Qn is compiled in with `define T_FLIPFLOP_QN_EN.
module t_flip_flop #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Q
`ifdef T_FLIPFLOP_QN_EN
  ,
  output logic [WIDTH-1:0] Qn
`endif
);

  logic [WIDTH-1:0] flip;

  // Bits never interact; counting is built outside via AND chains on T.
  assign flip = T & {WIDTH{En}};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Q <= RESET_VALUE;
    end else begin
      Q <= Q ^ flip;
    end
  end

`ifdef T_FLIPFLOP_QN_EN
  assign Qn = ~Q;
`endif

endmodule

// File: tb/tb_t_flip_flop.sv
// Self-checking bench for t_flip_flop: directed table, sequences,
// a 4-bit counter chain and randomized stimulus against a model.
module tb_t_flip_flop;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // single-bit instance
  logic       rst1, en1;
  logic [0:0] t1, q1;
  // vector instance with non-zero reset value
  logic       rst4, en4;
  logic [3:0] t4, q4;
  // random-test instance
  logic       rstr, enr;
  logic [7:0] tr, qr;
  // counter chain
  logic       rstc;
  logic [3:0] cq, ct;

`ifdef T_FLIPFLOP_QN_EN
  logic [0:0] qn1;
  logic [3:0] qn4, cqn;
  logic [7:0] qnr;
`endif

  t_flip_flop #(.WIDTH(1)) u1 (
    .Clk(clk), .Reset(rst1), .En(en1), .T(t1), .Q(q1)
`ifdef T_FLIPFLOP_QN_EN
    , .Qn(qn1)
`endif
  );

  t_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010)) u4 (
    .Clk(clk), .Reset(rst4), .En(en4), .T(t4), .Q(q4)
`ifdef T_FLIPFLOP_QN_EN
    , .Qn(qn4)
`endif
  );

  t_flip_flop #(.WIDTH(8)) ur (
    .Clk(clk), .Reset(rstr), .En(enr), .T(tr), .Q(qr)
`ifdef T_FLIPFLOP_QN_EN
    , .Qn(qnr)
`endif
  );

  assign ct[0] = 1'b1;
  assign ct[1] = cq[0];
  assign ct[2] = cq[0] & cq[1];
  assign ct[3] = cq[0] & cq[1] & cq[2];

  for (genvar g = 0; g < 4; g++) begin : g_chain
    t_flip_flop #(.WIDTH(1)) uc (
      .Clk(clk), .Reset(rstc), .En(1'b1), .T(ct[g]), .Q(cq[g])
`ifdef T_FLIPFLOP_QN_EN
      , .Qn(cqn[g])
`endif
    );
  end

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic e);
    check(name, {7'd0, q1}, {7'd0, e});
`ifdef T_FLIPFLOP_QN_EN
    check({name, "_qn"}, {7'd0, qn1}, {7'd0, ~e});
`endif
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] t;
    logic [3:0] exp;
  } vec_t;

  vec_t vt[9];
  logic m1;
  logic [7:0] mr;
  logic [3:0] mc;

  initial begin
    vt[0] = '{1'b1, 1'b1, 4'b0110, 4'b1010};
    vt[1] = '{1'b0, 1'b1, 4'b0110, 4'b1100};
    vt[2] = '{1'b0, 1'b1, 4'b0110, 4'b1010};
    vt[3] = '{1'b0, 1'b1, 4'b0110, 4'b1100};
    vt[4] = '{1'b1, 1'b1, 4'b0110, 4'b1010};
    vt[5] = '{1'b0, 1'b0, 4'b0110, 4'b1010};
    vt[6] = '{1'b0, 1'b1, 4'b0000, 4'b1010};
    vt[7] = '{1'b0, 1'b1, 4'b1111, 4'b0101};
    vt[8] = '{1'b0, 1'b1, 4'b0011, 4'b0110};

    rst1 = 1; en1 = 1; t1 = 1;
    rst4 = 1; en4 = 1; t4 = 4'b0110;
    rstr = 1; enr = 1; tr = 8'hff;
    rstc = 1;
    #2;
    tick(); tick();

    // reset state while clocks run with toggles requested
    chk1("rst_q1", 1'b0);
    check("rst_q4", {4'd0, q4}, 8'b1010);
    check("rst_qr", qr, 8'h00);
    check("rst_chain", {4'd0, cq}, 8'd0);

    // toggle sequence, no change on falling edges
    rst1 = 0;
    m1 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      m1 = ~m1;
      chk1($sformatf("toggle_%0d", i), m1);
      @(negedge clk); #1;
      chk1($sformatf("negedge_%0d", i), m1);
    end
    tick();
    m1 = ~m1;
    chk1("toggle_to1", m1);

    // hold via T
    t1 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("hold_t_%0d", i), 1'b1);
    end
    // hold via En
    en1 = 0; t1 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("hold_en_%0d", i), 1'b1);
    end

    // async reset between edges
    en1 = 1;
    @(negedge clk);
    rst1 = 1;
    #1;
    chk1("async_rst", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("rst_hold_%0d", i), 1'b0);
    end
    rst1 = 0;
    tick();
    chk1("release_first", 1'b1);
    tick();
    chk1("release_second", 1'b0);

    // reset rising in the same step as a clock edge
    @(posedge clk);
    rst1 = 1;
    #1;
    chk1("rst_vs_clk", 1'b0);
    tick();
    rst1 = 0;

    // counter chain 0..15 then wrap
    rstc = 0;
    mc = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      mc = 4'((i) % 16);
      check($sformatf("chain_%0d", i), {4'd0, cq}, {4'd0, mc});
    end

    // vector table on WIDTH=4 instance
    for (int i = 0; i < 9; i++) begin
      rst4 = vt[i].rst; en4 = vt[i].en; t4 = vt[i].t;
      if (vt[i].rst) #1;
      else tick();
      check($sformatf("vec_%0d", i), {4'd0, q4}, {4'd0, vt[i].exp});
`ifdef T_FLIPFLOP_QN_EN
      check($sformatf("vec_qn_%0d", i), {4'd0, qn4}, {4'd0, ~vt[i].exp});
`endif
    end

    // randomized against the toggle rule
    mr = 0;
    for (int i = 0; i < 300; i++) begin
      rstr = ($urandom_range(15) == 0);
      enr  = 1'($urandom);
      tr   = 8'($urandom);
      #1;
      if (rstr) begin
        mr = 0;
        check($sformatf("rnd_async_%0d", i), qr, mr);
      end
      tick();
      if (!rstr && enr) mr = mr ^ tr;
      check($sformatf("rnd_%0d", i), qr, mr);
`ifdef T_FLIPFLOP_QN_EN
      check($sformatf("rnd_qn_%0d", i), qnr, ~mr);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
